// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller.
package alu_issue_ctrl_pkg;

  localparam int OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] LAST_OPCODE = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // A response closes its command when it is a single op, or the final sweep opcode.
  function automatic logic is_final(input logic sweep, input logic [OPCODE_W-1:0] op);
    return !sweep || (op == LAST_OPCODE);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts a single op or a 16-op sweep, drives registered
// operands/opcode to an external combinational ALU, and holds each result as a
// valid/ready response until the consumer takes it.
//
//   state | meaning
//   IDLE  | waiting for a command; ALU inputs hold their last values
//   EXEC  | ALU inputs settled for one cycle; result captured at its closing edge
//   HOLD  | response presented; advances (next sweep op or IDLE) on rsp_ready
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_sweep,
  input  logic [OPCODE_W-1:0]   cmd_opcode,
  input  logic [DATA_W-1:0]     cmd_a,
  input  logic [DATA_W-1:0]     cmd_b,
  output logic [DATA_W-1:0]     operand1,
  output logic [DATA_W-1:0]     operand2,
  output logic [OPCODE_W-1:0]   opcode,
  input  logic [2*DATA_W-1:0]   result,
  input  logic                  flagC,
  input  logic                  flagZ,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_result,
  output logic                  rsp_flagC,
  output logic                  rsp_flagZ,
  output logic [OPCODE_W-1:0]   rsp_opcode,
  output logic                  rsp_last,
  output logic [15:0]           op_count
);

  state_t state;
  state_t state_nxt;
  logic   sweep_mode;
  logic   accept;
  logic   handshake;
  logic   sweep_more;

  assign accept     = cmd_valid & cmd_ready;
  assign handshake  = rsp_valid & rsp_ready;
  // The sweep stops at the last opcode rather than wrapping back to zero.
  assign sweep_more = sweep_mode && (opcode != LAST_OPCODE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_HOLD;
      ST_HOLD: if (rsp_ready) state_nxt = sweep_more ? ST_EXEC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_HOLD);
  end

  // ALU input registers: loaded on accept, stepped during a sweep, otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand1   <= '0;
      operand2   <= '0;
      opcode     <= '0;
      sweep_mode <= 1'b0;
    end else if (accept) begin
      operand1   <= cmd_a;
      operand2   <= cmd_b;
      opcode     <= cmd_sweep ? '0 : cmd_opcode;
      sweep_mode <= cmd_sweep;
    end else if (handshake && sweep_more) begin
      opcode     <= opcode + 4'd1;
    end
  end

  // Response registers: captured only at the end of EXEC, so they stay frozen through HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_flagC  <= 1'b0;
      rsp_flagZ  <= 1'b0;
      rsp_opcode <= '0;
      rsp_last   <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_result <= result;
      rsp_flagC  <= flagC;
      rsp_flagZ  <= flagZ;
      rsp_opcode <= opcode;
      rsp_last   <= is_final(sweep_mode, opcode);
    end
  end

  // Count of accepted responses; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            op_count <= '0;
    else if (handshake) op_count <= op_count + 16'd1;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural 8-bit ALU behind it.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_sweep;
  logic [3:0]  cmd_opcode;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [7:0]  operand1;
  logic [7:0]  operand2;
  logic [3:0]  opcode;
  logic [15:0] result;
  logic        flagC;
  logic        flagZ;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_flagC;
  logic        rsp_flagZ;
  logic [3:0]  rsp_opcode;
  logic        rsp_last;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;
  int model_count = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: returns {carry, result}.
  function automatic logic [16:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
    logic [15:0] r;
    logic [8:0]  t;
    logic        c;
    r = 16'h0;
    t = 9'h0;
    c = 1'b0;
    case (op)
      4'd0:  begin t = {1'b0, a} + {1'b0, b}; r = {8'h00, t[7:0]}; c = t[8]; end
      4'd1:  begin t = {1'b0, a} - {1'b0, b}; r = {8'h00, t[7:0]}; c = t[8]; end
      4'd2:  r = {8'h00, a & b};
      4'd3:  r = {8'h00, a | b};
      4'd4:  r = {8'h00, a ^ b};
      4'd5:  r = {8'h00, ~a};
      4'd6:  r = {8'h00, a} * {8'h00, b};
      4'd7:  begin t = {a, 1'b0}; r = {8'h00, t[7:0]}; c = t[8]; end
      4'd8:  begin r = {8'h00, 1'b0, a[7:1]}; c = a[0]; end
      4'd9:  begin t = {1'b0, a} + 9'd1; r = {8'h00, t[7:0]}; c = t[8]; end
      4'd10: begin t = {1'b0, a} - 9'd1; r = {8'h00, t[7:0]}; c = t[8]; end
      4'd11: r = {8'h00, a};
      4'd12: r = {8'h00, b};
      4'd13: r = {8'h00, ~(a & b)};
      4'd14: r = {8'h00, ~(a | b)};
      default: r = {8'h00, ~(a ^ b)};
    endcase
    return {c, r};
  endfunction

  logic [16:0] alu_out;
  always_comb alu_out = alu_ref(operand1, operand2, opcode);
  assign result = alu_out[15:0];
  assign flagC  = alu_out[16];
  assign flagZ  = (alu_out[15:0] == 16'h0);

  alu_issue_ctrl #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sweep(cmd_sweep),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .operand1(operand1), .operand2(operand2), .opcode(opcode),
    .result(result), .flagC(flagC), .flagZ(flagZ),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flagC(rsp_flagC), .rsp_flagZ(rsp_flagZ),
    .rsp_opcode(rsp_opcode), .rsp_last(rsp_last), .op_count(op_count)
  );

  // Runs one command against the reference. stall<0 picks random stalls per response.
  // abort_at>=0 asserts reset while the response with that index is held.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic sweep, input int stall, input int abort_at);
    int          n_rsp;
    int          n_stall;
    logic [3:0]  k;
    logic [16:0] e;
    logic [23:0] exp_rsp;
    logic [23:0] got_rsp;
    logic        seen_valid;
    n_rsp = sweep ? 16 : 1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_sweep = sweep;
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_opcode = 4'($urandom);
    cmd_sweep = 1'($urandom);
    checks++;
    if ({operand1, operand2, opcode, rsp_valid, cmd_ready} !== {a, b, (sweep ? 4'd0 : op), 2'b00}) begin
      errors++;
      $display("FAIL exec_drive: got op1=%h op2=%h opc=%h v=%b rdy=%b expected op1=%h op2=%h opc=%h v=0 rdy=0",
               operand1, operand2, opcode, rsp_valid, cmd_ready, a, b, (sweep ? 4'd0 : op));
    end
    for (int i = 0; i < n_rsp; i++) begin
      k = sweep ? 4'(i) : op;
      e = alu_ref(a, b, k);
      exp_rsp = {1'b1, k, (!sweep || i == 15), e[16], (e[15:0] == 16'h0), e[15:0]};
      @(posedge clk); #1;
      got_rsp = {rsp_valid, rsp_opcode, rsp_last, rsp_flagC, rsp_flagZ, rsp_result};
      checks++;
      if (got_rsp !== exp_rsp) begin
        errors++; $display("FAIL rsp_hold_entry[%0d]: got %h expected %h", i, got_rsp, exp_rsp);
      end
      checks++;
      if ({cmd_ready, op_count} !== {1'b0, 16'(model_count)}) begin
        errors++; $display("FAIL busy_count[%0d]: got rdy=%b cnt=%0d expected rdy=0 cnt=%0d",
                           i, cmd_ready, op_count, model_count);
      end
      if (abort_at == i) begin
        #2; rst = 1'b1; #1;
        checks++;
        if ({operand1, operand2, opcode, rsp_result, rsp_flagC, rsp_flagZ, rsp_last, rsp_opcode,
             op_count, rsp_valid, cmd_ready} !== {71'h0, 1'b1}) begin
          errors++;
          $display("FAIL async_reset: got op1=%h op2=%h opc=%h res=%h c=%b z=%b last=%b ropc=%h cnt=%h v=%b rdy=%b expected all 0, rdy=1",
                   operand1, operand2, opcode, rsp_result, rsp_flagC, rsp_flagZ, rsp_last,
                   rsp_opcode, op_count, rsp_valid, cmd_ready);
        end
        @(negedge clk); rst = 1'b0; model_count = 0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
          errors++; $display("FAIL post_reset_ready: got rdy=%b v=%b expected rdy=1 v=0", cmd_ready, rsp_valid);
        end
        seen_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) seen_valid = 1'b1;
        end
        checks++;
        if ({seen_valid, op_count} !== 17'h0) begin
          errors++; $display("FAIL no_resume_after_reset: got stray=%b cnt=%0d expected stray=0 cnt=0",
                             seen_valid, op_count);
        end
        rsp_ready = 1'b0;
        return;
      end
      n_stall = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int s = 0; s < n_stall; s++) begin
        @(posedge clk); #1;
        got_rsp = {rsp_valid, rsp_opcode, rsp_last, rsp_flagC, rsp_flagZ, rsp_result};
        checks++;
        if (got_rsp !== exp_rsp || operand1 !== a || operand2 !== b) begin
          errors++;
          $display("FAIL backpressure[%0d.%0d]: got rsp=%h op1=%h op2=%h expected rsp=%h op1=%h op2=%h",
                   i, s, got_rsp, operand1, operand2, exp_rsp, a, b);
        end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      model_count++;
      checks++;
      if (op_count !== 16'(model_count)) begin
        errors++; $display("FAIL op_count: got %0d expected %0d", op_count, model_count);
      end
      checks++;
      if (i < n_rsp - 1) begin
        if ({rsp_valid, cmd_ready, opcode} !== {2'b00, 4'(k + 4'd1)}) begin
          errors++; $display("FAIL sweep_step[%0d]: got v=%b rdy=%b opc=%h expected v=0 rdy=0 opc=%h",
                             i, rsp_valid, cmd_ready, opcode, 4'(k + 4'd1));
        end
      end else begin
        if ({rsp_valid, cmd_ready, opcode, operand1, operand2} !== {2'b01, k, a, b}) begin
          errors++;
          $display("FAIL idle_hold: got v=%b rdy=%b opc=%h op1=%h op2=%h expected v=0 rdy=1 opc=%h op1=%h op2=%h",
                   rsp_valid, cmd_ready, opcode, operand1, operand2, k, a, b);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_sweep = 1'b0; cmd_opcode = 4'h0;
    cmd_a = 8'h0; cmd_b = 8'h0; rsp_ready = 1'b0;
    #12;
    checks++;
    if ({operand1, operand2, opcode, rsp_result, rsp_flagC, rsp_flagZ, rsp_last, rsp_opcode,
         op_count, rsp_valid, cmd_ready} !== {71'h0, 1'b1}) begin
      errors++; $display("FAIL reset_state: got op1=%h op2=%h opc=%h res=%h cnt=%h v=%b rdy=%b expected zeros, rdy=1",
                         operand1, operand2, opcode, rsp_result, op_count, rsp_valid, cmd_ready);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_release: got rdy=%b v=%b expected rdy=1 v=0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_single();       run_cmd(8'hAA, 8'h55, 4'd3, 1'b0, 0, -1); endtask
  task automatic test_sweep();        run_cmd(8'hAA, 8'h55, 4'd9, 1'b1, 0, -1); endtask
  task automatic test_backpressure(); run_cmd(8'hC3, 8'h7E, 4'd6, 1'b0, 5, -1); endtask

  task automatic test_zero_result();
    run_cmd(8'h00, 8'h00, 4'd0, 1'b0, 1, -1);
    checks++;
    if ({rsp_result, rsp_flagZ} !== {16'h0000, 1'b1}) begin
      errors++; $display("FAIL zero_result: got res=%h z=%b expected res=0000 z=1", rsp_result, rsp_flagZ);
    end
  endtask

  task automatic test_cmd_held();
    logic [16:0] e;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_sweep = 1'b0; cmd_a = 8'h12; cmd_b = 8'h34; cmd_opcode = 4'd0;
    @(posedge clk); #1;
    cmd_a = 8'h56; cmd_b = 8'h78; cmd_opcode = 4'd1;
    @(posedge clk); #1;
    e = alu_ref(8'h12, 8'h34, 4'd0);
    checks++;
    if ({rsp_valid, cmd_ready, operand1, rsp_result} !== {2'b10, 8'h12, e[15:0]}) begin
      errors++; $display("FAIL held_hold: got v=%b rdy=%b op1=%h res=%h expected v=1 rdy=0 op1=12 res=%h",
                         rsp_valid, cmd_ready, operand1, rsp_result, e[15:0]);
    end
    @(posedge clk); #1;
    model_count++;
    checks++;
    if ({cmd_ready, rsp_valid, operand1, opcode} !== {2'b10, 8'h12, 4'd0}) begin
      errors++; $display("FAIL held_idle: got rdy=%b v=%b op1=%h opc=%h expected rdy=1 v=0 op1=12 opc=0",
                         cmd_ready, rsp_valid, operand1, opcode);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if ({cmd_ready, operand1, operand2, opcode} !== {1'b0, 8'h56, 8'h78, 4'd1}) begin
      errors++; $display("FAIL held_accept: got rdy=%b op1=%h op2=%h opc=%h expected rdy=0 op1=56 op2=78 opc=1",
                         cmd_ready, operand1, operand2, opcode);
    end
    @(posedge clk); #1;
    e = alu_ref(8'h56, 8'h78, 4'd1);
    checks++;
    if ({rsp_valid, rsp_result, rsp_flagC, rsp_last} !== {1'b1, e[15:0], e[16], 1'b1}) begin
      errors++; $display("FAIL held_second_rsp: got v=%b res=%h c=%b last=%b expected v=1 res=%h c=%b last=1",
                         rsp_valid, rsp_result, rsp_flagC, rsp_last, e[15:0], e[16]);
    end
    @(posedge clk); #1;
    model_count++;
    rsp_ready = 1'b0;
    checks++;
    if ({cmd_ready, op_count} !== {1'b1, 16'(model_count)}) begin
      errors++; $display("FAIL held_count: got rdy=%b cnt=%0d expected rdy=1 cnt=%0d", cmd_ready, op_count, model_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      run_cmd(8'($urandom), 8'($urandom), 4'($urandom), 1'b0, 0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++)
      run_cmd(8'($urandom), 8'($urandom), 4'($urandom), ($urandom_range(0, 5) == 0), -1, -1);
  endtask

  task automatic test_reset_mid_sweep(); run_cmd(8'hAA, 8'h55, 4'd0, 1'b1, -1, 7); endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_backpressure();
    test_zero_result();
    test_cmd_held();
    test_back_to_back();
    test_random();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
